// File: rtl/multdiv_sequencer_pkg.sv
// Processor constants shared by the execute-stage multiply/divide sequencer.
// Op codes, rstatus codes and the sequencer state encoding.
package multdiv_sequencer_pkg;

    localparam logic [4:0]  OP_MUL      = 5'b00110;
    localparam logic [4:0]  OP_DIV      = 5'b00111;
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;
    localparam logic [4:0]  RSTATUS_REG = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic [31:0] rstatus_code(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/multdiv_sequencer.sv
// Purpose: starts the iterative mul/div unit for a D/X mul/div op, stalls the pipe, hands result to X/M.
// Latency: detect + START + >=1 BUSY + DONE; result valid for one cycle in DONE.
// Backpressure: stall held from detect until DONE; flush aborts the unit and drops the result.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_valid,
    input  logic [4:0]  dx_alu_op,
    input  logic        dx_is_rtype,
    input  logic [4:0]  dx_rd,
    input  logic [31:0] dx_a,
    input  logic [31:0] dx_b,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_result_rdy,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic        md_abort,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_result,
    output logic        wb_exception,
    output logic [31:0] wb_rstatus
);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic [4:0]         rd_q;
    logic               req;
    logic               timeout;
    logic               cap_exc;
    logic [31:0]        cap_res;

    assign req     = dx_valid && dx_is_rtype && is_md_op(dx_alu_op);
    assign timeout = (cnt == CNT_W'(MAX_CYCLES - 1));

    // A ready result always wins over a coincident timeout.
    assign cap_exc = md_result_rdy ? md_exception : 1'b1;
    assign cap_res = (md_result_rdy && !md_exception) ? md_result : 32'd0;

    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE:           stall = req && !flush;
                ST_START, ST_BUSY: stall = !flush;
                default:           stall = 1'b0;
            endcase
        end
    end

    assign wb_valid = (state == ST_DONE) && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            op_div       <= 1'b0;
            rd_q         <= '0;
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            md_abort     <= 1'b0;
            md_operand_a <= '0;
            md_operand_b <= '0;
            wb_rd        <= '0;
            wb_result    <= '0;
            wb_exception <= 1'b0;
            wb_rstatus   <= '0;
        end else begin
            md_ctrl_mult <= 1'b0;
            md_ctrl_div  <= 1'b0;
            md_abort     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req && !flush) begin
                        md_operand_a <= dx_a;
                        md_operand_b <= dx_b;
                        rd_q         <= dx_rd;
                        op_div       <= (dx_alu_op == OP_DIV);
                        md_ctrl_mult <= (dx_alu_op != OP_DIV);
                        md_ctrl_div  <= (dx_alu_op == OP_DIV);
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    if (flush) begin
                        md_abort <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        md_abort <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (md_result_rdy || timeout) begin
                            wb_rd        <= rd_q;
                            wb_result    <= cap_res;
                            wb_exception <= cap_exc;
                            wb_rstatus   <= cap_exc ? rstatus_code(op_div) : 32'd0;
                            state        <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with a cycle-level reference model and a datapath stand-in.
module tb_multdiv_sequencer;

    localparam int MAXC = 40;

    logic        clock, reset;
    logic        dx_valid, dx_is_rtype, flush;
    logic [4:0]  dx_alu_op, dx_rd;
    logic [31:0] dx_a, dx_b, md_result;
    logic        md_exception, md_result_rdy;
    logic        md_ctrl_mult, md_ctrl_div, md_abort, stall, wb_valid, wb_exception;
    logic [31:0] md_operand_a, md_operand_b, wb_result, wb_rstatus;
    logic [4:0]  wb_rd;

    multdiv_sequencer dut (
        .clock(clock), .reset(reset), .dx_valid(dx_valid), .dx_alu_op(dx_alu_op),
        .dx_is_rtype(dx_is_rtype), .dx_rd(dx_rd), .dx_a(dx_a), .dx_b(dx_b), .flush(flush),
        .md_result(md_result), .md_exception(md_exception), .md_result_rdy(md_result_rdy),
        .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_abort(md_abort),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
        .wb_exception(wb_exception), .wb_rstatus(wb_rstatus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference model: age<0 idle, 0 = start cycle, k>=1 = k-th busy cycle.
    int          m_age = -1;
    logic        m_done = 0, m_abort = 0, m_div = 0;
    logic [4:0]  m_rd = 0, w_rd = 0;
    logic [31:0] m_a = 0, m_b = 0, w_res = 0, w_rst = 0;
    logic        w_exc = 0;

    always @(negedge clock) begin
        logic rq, e_stall, e_wbv, new_abort, ex;
        rq = dx_valid && dx_is_rtype && (dx_alu_op == 5'd6 || dx_alu_op == 5'd7);
        if (!reset) begin
            m_age = -1; m_done = 0; m_abort = 0; m_div = 0;
            m_a = 0; m_b = 0; m_rd = 0;
            chk("rst_stall", stall, 0);
            chk("rst_wbv", wb_valid, 0);
            chk("rst_pulses", {md_ctrl_mult, md_ctrl_div, md_abort}, 0);
            chk("rst_wb", {wb_rd, wb_exception} | wb_result | wb_rstatus, 0);
        end else begin
            e_stall = (m_age < 0 && !m_done && rq && !flush) || (m_age >= 0 && !flush);
            e_wbv   = m_done && !flush;
            chk("stall", stall, e_stall);
            chk("ctrl_mult", md_ctrl_mult, m_age == 0 && !m_div);
            chk("ctrl_div", md_ctrl_div, m_age == 0 && m_div);
            chk("abort", md_abort, m_abort);
            chk("wb_valid", wb_valid, e_wbv);
            chk("operand_a", md_operand_a, m_a);
            chk("operand_b", md_operand_b, m_b);
            if (e_wbv) begin
                chk("wb_rd", wb_rd, w_rd);
                chk("wb_result", wb_result, w_res);
                chk("wb_exception", wb_exception, w_exc);
                chk("wb_rstatus", wb_rstatus, w_rst);
            end
            new_abort = (m_age >= 0) && flush;
            if (m_done) m_done = 0;
            else if (m_age < 0) begin
                if (rq && !flush) begin
                    m_age = 0; m_a = dx_a; m_b = dx_b; m_rd = dx_rd; m_div = (dx_alu_op == 5'd7);
                end
            end else if (flush) m_age = -1;
            else if (m_age == 0) m_age = 1;
            else if (md_result_rdy || m_age == MAXC) begin
                ex    = md_result_rdy ? md_exception : 1'b1;
                w_exc = ex;
                w_res = ex ? 32'd0 : md_result;
                w_rst = ex ? (m_div ? 32'd5 : 32'd4) : 32'd0;
                w_rd  = m_rd;
                m_done = 1; m_age = -1;
            end else m_age++;
            m_abort = new_abort;
        end
    end

    // Monitor: pulse counts, stall-run lengths, cycle stamps and the writeback log.
    int cyc = 0, run = 0, last_run = 0;
    int mult_cnt = 0, div_cnt = 0, abort_cnt = 0, wb_cnt = 0, div_cyc = 0, wb_cyc = 0;
    logic [4:0]  q_rd[$];
    logic [31:0] q_res[$], q_rst[$];
    logic        q_exc[$];

    always @(posedge clock) cyc++;
    always @(negedge clock) begin
        if (stall) run++;
        else if (run > 0) begin last_run = run; run = 0; end
        if (md_ctrl_mult) mult_cnt++;
        if (md_ctrl_div) begin div_cnt++; div_cyc = cyc; end
        if (md_abort) abort_cnt++;
        if (wb_valid) begin
            wb_cnt++; wb_cyc = cyc;
            q_rd.push_back(wb_rd); q_res.push_back(wb_result);
            q_exc.push_back(wb_exception); q_rst.push_back(wb_rstatus);
        end
    end

    // Datapath stand-in: raises rdy for one cycle dp_delay cycles after a start pulse (0 = never).
    int dp_delay = 0, dp_cnt = 0;
    initial begin
        md_result_rdy = 0;
        forever begin
            @(posedge clock); #1;
            if (dp_cnt > 0) begin dp_cnt--; md_result_rdy = (dp_cnt == 0); end
            else md_result_rdy = 0;
            @(negedge clock);
            if ((md_ctrl_mult || md_ctrl_div) && dp_delay > 0) dp_cnt = dp_delay;
        end
    end

    task automatic set_instr(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a, b,
                             input int dly, input logic [31:0] res, input logic exc);
        dp_delay = dly; md_result = res; md_exception = exc;
        dx_valid = 1; dx_is_rtype = 1; dx_alu_op = op; dx_rd = rd; dx_a = a; dx_b = b;
    endtask

    // Holds the instruction in D/X until the pipeline lets it advance.
    task automatic run_instr(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] a, b,
                             input int dly, input logic [31:0] res, input logic exc);
        bit ok = 0;
        set_instr(op, rd, a, b, dly, res, exc);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!stall) begin ok = 1; break; end
        end
        if (!ok) chk("instr_leaves_dx_timeout", 0, 1);
        @(posedge clock); #1;
        dx_valid = 0;
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (md_ctrl_mult || md_ctrl_div) begin ok = 1; break; end
        end
        if (!ok) chk("start_pulse_timeout", 0, 1);
    endtask

    task automatic flush_test(input int dly);
        int a0, w0;
        a0 = abort_cnt; w0 = wb_cnt;
        set_instr(5'd6, 5'd4, 32'd2, 32'd3, dly, 32'd6, 1'b0);
        wait_start();
        repeat (10) @(posedge clock);
        #1 flush = 1;
        @(negedge clock);
        chk("flush_stall_low", stall, 0);
        chk("flush_wbv_low", wb_valid, 0);
        @(posedge clock); #1;
        flush = 0; dx_valid = 0;
        @(negedge clock);
        chk("flush_abort_high", md_abort, 1);
        repeat (8) @(posedge clock);
        #1;
        chk("flush_abort_once", abort_cnt - a0, 1);
        chk("flush_no_wb", wb_cnt - w0, 0);
    endtask

    initial begin
        int m0, w0;
        reset = 1; flush = 0; dx_valid = 0; dx_is_rtype = 0; dx_alu_op = 0; dx_rd = 0;
        dx_a = 0; dx_b = 0; md_result = 0; md_exception = 0;
        #2 reset = 0;
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_operand_a", md_operand_a, 0);
        chk("reset_wb_result", wb_result, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1;

        // mul r3 = 3*7, rdy 33 cycles after the start pulse
        m0 = mult_cnt; w0 = wb_cnt;
        run_instr(5'd6, 5'd3, 32'd3, 32'd7, 33, 32'd21, 1'b0);
        chk("t1_mult_pulses", mult_cnt - m0, 1);
        chk("t1_stall_run", last_run, 35);
        chk("t1_wb_count", wb_cnt - w0, 1);
        chk("t1_result", q_res[$], 32'd21);
        chk("t1_rd", q_rd[$], 5'd3);
        chk("t1_exc", q_exc[$], 0);
        chk("t1_rstatus", q_rst[$], 0);

        // div 100/0 with datapath exception; garbage result must be zeroed
        run_instr(5'd7, 5'd8, 32'd100, 32'd0, 5, 32'hDEAD_BEEF, 1'b1);
        chk("t2_result", q_res[$], 0);
        chk("t2_exc", q_exc[$], 1);
        chk("t2_rstatus", q_rst[$], 32'd5);
        chk("t2_rd", q_rd[$], 5'd8);

        // mul that never gets rdy: timeout after 40 busy cycles
        run_instr(5'd6, 5'd11, 32'd9, 32'd9, 0, 32'd81, 1'b0);
        chk("t3_stall_run", last_run, MAXC + 2);
        chk("t3_exc", q_exc[$], 1);
        chk("t3_rstatus", q_rst[$], 32'd4);
        chk("t3_result", q_res[$], 0);

        // flush on the 10th busy cycle, alone and coincident with rdy
        flush_test(0);
        flush_test(10);

        // back-to-back mul then div
        w0 = wb_cnt;
        run_instr(5'd6, 5'd5, 32'd6, 32'd7, 3, 32'd42, 1'b0);
        chk("t5_done1_cycle_seen", wb_cnt - w0, 1);
        m0 = wb_cyc;
        run_instr(5'd7, 5'd9, 32'd84, 32'd2, 4, 32'd42, 1'b0);
        chk("t5_start2_gap", div_cyc - m0, 2);
        chk("t5_wb_count", wb_cnt - w0, 2);
        chk("t5_rd1", q_rd[q_rd.size()-2], 5'd5);
        chk("t5_rd2", q_rd[$], 5'd9);
        chk("t5_res2", q_res[$], 32'd42);

        // async reset mid-busy, then a late rdy must be ignored
        w0 = wb_cnt;
        set_instr(5'd6, 5'd12, 32'd5, 32'd5, 20, 32'd25, 1'b0);
        wait_start();
        repeat (5) @(posedge clock);
        #3 reset = 0;
        #1;
        chk("t6_stall", stall, 0);
        chk("t6_pulses", {md_ctrl_mult, md_ctrl_div, md_abort}, 0);
        chk("t6_operands", md_operand_a | md_operand_b, 0);
        chk("t6_wb", {wb_valid, wb_exception, wb_rd} | wb_result | wb_rstatus, 0);
        repeat (2) @(posedge clock);
        #1 dx_valid = 0; reset = 1;
        repeat (30) @(posedge clock);
        #1;
        chk("t6_no_wb_after_reset", wb_cnt - w0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
